// File: rtl/responder_es.sv
// responder_es: CPU I/O window responder with wait states, 4 out/in ports and a 7-source edge IRQ controller.
module responder_es #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_wishbone,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] dir,
  input  logic [7:0]  dato_escritura,
  output logic [7:0]  dato_lectura,
  output logic        cpu_wait,
  output logic [2:0]  interrupciones,
  output logic [31:0] puertos_salida,
  input  logic [31:0] puertos_entrada,
  input  logic [6:0]  irq_in
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0][7:0] out_q;
  logic [3:0][7:0] in_s1_q, in_s2_q;
  logic [6:0]      irq_s1_q, irq_s2_q, irq_s3_q, pend_q, mask_q;
  logic [7:0]      rdata_q;
  logic [2:0]      irq_q;
  logic            hit, commit, wr_en;
  logic [3:0]      off;
  logic [7:0]      rd_val;
  logic [6:0]      clr, act, pend_d;
  logic [2:0]      irq_d;
  assign hit            = enable_wishbone && (dir[15:4] == BASE_ADDR[15:4]);
  assign off            = dir[3:0];
  assign commit         = hit && ((state_q == S_IDLE && WAIT_STATES == 0) ||
                                  (state_q == S_WAIT && cnt_q == 4'd0));
  assign wr_en          = commit && wr;
  assign cpu_wait       = hit && (state_q != S_DONE) && !reset;
  assign dato_lectura   = rdata_q;
  assign interrupciones = irq_q;
  assign puertos_salida = out_q;
  always_comb begin
    rd_val = off[3:2] == 2'd0 ? out_q[off[1:0]] :
             off[3:2] == 2'd1 ? in_s2_q[off[1:0]] :
             off == 4'd8      ? {1'b0, pend_q} :
             off == 4'd9      ? {1'b0, mask_q} : 8'h00;
    clr    = (wr_en && off == 4'd8) ? dato_escritura[6:0] : 7'h00;
    // a new edge wins over a same-cycle write-1-to-clear
    pend_d = (pend_q & ~clr) | (irq_s2_q & ~irq_s3_q);
    act    = pend_q & mask_q;
    irq_d  = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (act[i]) irq_d = 3'(i + 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      out_q    <= '0;
      in_s1_q  <= '0;
      in_s2_q  <= '0;
      irq_s1_q <= '0;
      irq_s2_q <= '0;
      irq_s3_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= 8'h00;
      irq_q    <= 3'd0;
    end else begin
      in_s1_q  <= puertos_entrada;
      in_s2_q  <= in_s1_q;
      irq_s1_q <= irq_in;
      irq_s2_q <= irq_s1_q;
      irq_s3_q <= irq_s2_q;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      if (wr_en && off[3:2] == 2'd0) out_q[off[1:0]] <= dato_escritura;
      if (wr_en && off == 4'd9) mask_q <= dato_escritura[6:0];
      rdata_q  <= commit ? ((rd && !wr) ? rd_val : 8'h00) :
                  (state_q == S_DONE ? 8'h00 : rdata_q);
      case (state_q)
        S_IDLE: if (hit) begin
          state_q <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
          cnt_q   <= WS_LAST;
        end
        S_WAIT: begin
          state_q <= !hit ? S_IDLE : (cnt_q == 4'd0 ? S_DONE : S_WAIT);
          cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_responder_es.sv
// tb_responder_es: directed checks of bus timing, register map, IRQ controller and reset abort.
module tb_responder_es;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable_wishbone, rd, wr;
  logic [15:0] dir;
  logic [7:0]  dato_escritura, dato_lectura;
  logic        cpu_wait;
  logic [2:0]  interrupciones;
  logic [31:0] puertos_salida, puertos_entrada;
  logic [6:0]  irq_in;
  int          total = 0, passed = 0, w;
  logic [7:0]  r;

  responder_es dut (
    .clk(clk), .reset(reset), .enable_wishbone(enable_wishbone), .rd(rd), .wr(wr),
    .dir(dir), .dato_escritura(dato_escritura), .dato_lectura(dato_lectura),
    .cpu_wait(cpu_wait), .interrupciones(interrupciones), .puertos_salida(puertos_salida),
    .puertos_entrada(puertos_entrada), .irq_in(irq_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starts at a falling edge; returns at the falling edge after the DONE cycle.
  task automatic acc(input logic wnr, input logic [15:0] a, input logic [7:0] d,
                     output int waits, output logic [7:0] rdata);
    enable_wishbone = 1'b1; rd = ~wnr; wr = wnr; dir = a; dato_escritura = d; waits = 0;
    #1;
    while (cpu_wait && waits < 40) begin
      waits++;
      @(negedge clk);
      #1;
    end
    rdata = dato_lectura;
    @(negedge clk);
    enable_wishbone = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable_wishbone = 1'b1; rd = 1'b1; wr = 1'b0; dir = 16'hFF00;
    dato_escritura = 8'h00; puertos_entrada = 32'h0; irq_in = 7'h0;
    repeat (2) @(negedge clk);
    check("rst_wait", cpu_wait, 1'b0);
    check("rst_rdata", dato_lectura, 8'h00);
    check("rst_ports", puertos_salida, 32'h0);
    check("rst_irq", interrupciones, 3'd0);
    reset = 1'b0; enable_wishbone = 1'b0; rd = 1'b0;
    @(negedge clk);
    // T1 write out port 2
    acc(1'b1, 16'hFF02, 8'hA5, w, r);
    check("t1_waits", w, 3);
    check("t1_port", puertos_salida, 32'h00A50000);
    check("t1_rdata_idle", dato_lectura, 8'h00);
    acc(1'b0, 16'hFF02, 8'h00, w, r);
    check("t1_readback", r, 8'hA5);
    // T2 synced input port 1
    puertos_entrada = 32'h00003C00;
    repeat (3) @(negedge clk);
    acc(1'b0, 16'hFF05, 8'h00, w, r);
    check("t2_waits", w, 3);
    check("t2_rdata_done", r, 8'h3C);
    check("t2_rdata_after", dato_lectura, 8'h00);
    acc(1'b0, 16'hFF04, 8'h00, w, r);
    check("t2_inport0", r, 8'h00);
    acc(1'b1, 16'hFF0A, 8'h55, w, r);
    acc(1'b0, 16'hFF0A, 8'h00, w, r);
    check("unmapped_read", r, 8'h00);
    acc(1'b1, 16'hFF09, 8'hFF, w, r);
    acc(1'b0, 16'hFF09, 8'h00, w, r);
    check("mask_bit7_zero", r, 8'h7F);
    // T3 priority and W1C
    irq_in[4] = 1'b1; repeat (2) @(negedge clk); irq_in = 7'h0; repeat (4) @(negedge clk);
    check("t3_irq4", interrupciones, 3'd5);
    irq_in[1] = 1'b1; repeat (2) @(negedge clk); irq_in = 7'h0; repeat (4) @(negedge clk);
    check("t3_irq1", interrupciones, 3'd2);
    acc(1'b0, 16'hFF08, 8'h00, w, r);
    check("t3_pending", r, 8'h12);
    acc(1'b1, 16'hFF08, 8'h02, w, r);
    repeat (2) @(negedge clk);
    check("t3_after_w1c", interrupciones, 3'd5);
    // T4 set beats same-edge clear
    irq_in[3] = 1'b1; repeat (2) @(negedge clk); irq_in = 7'h0; repeat (4) @(negedge clk);
    check("t4_irq3", interrupciones, 3'd4);
    irq_in[3] = 1'b1;
    acc(1'b1, 16'hFF08, 8'h08, w, r);
    irq_in = 7'h0;
    acc(1'b0, 16'hFF08, 8'h00, w, r);
    check("t4_set_wins", r, 8'h18);
    repeat (4) @(negedge clk);
    acc(1'b1, 16'hFF08, 8'h08, w, r);
    acc(1'b0, 16'hFF08, 8'h00, w, r);
    check("t4_plain_clear", r, 8'h10);
    repeat (2) @(negedge clk);
    check("t4_irq_back", interrupciones, 3'd5);
    // T5 access outside the window
    enable_wishbone = 1'b1; rd = 1'b1; wr = 1'b1; dir = 16'h1234; dato_escritura = 8'h77;
    #1;
    check("t5_wait", cpu_wait, 1'b0);
    check("t5_rdata", dato_lectura, 8'h00);
    @(negedge clk);
    dir = 16'h1202;
    repeat (2) @(negedge clk);
    check("t5_ports", puertos_salida, 32'h00A50000);
    enable_wishbone = 1'b0; rd = 1'b0; wr = 1'b0;
    acc(1'b0, 16'hFF02, 8'h00, w, r);
    check("t5_fresh_waits", w, 3);
    check("t5_port2_kept", r, 8'hA5);
    // T6 reset mid-access
    enable_wishbone = 1'b1; rd = 1'b0; wr = 1'b1; dir = 16'hFF00; dato_escritura = 8'hFF;
    @(negedge clk);
    #1;
    check("t6_in_wait", cpu_wait, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_wait_forced", cpu_wait, 1'b0);
    check("t6_irq_cleared", interrupciones, 3'd0);
    @(negedge clk);
    reset = 1'b0; enable_wishbone = 1'b0; wr = 1'b0;
    check("t6_ports", puertos_salida, 32'h0);
    @(negedge clk);
    acc(1'b0, 16'hFF00, 8'h00, w, r);
    check("t6_idle_waits", w, 3);
    check("t6_port0", r, 8'h00);
    acc(1'b0, 16'hFF09, 8'h00, w, r);
    check("t6_mask", r, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
